// File: rtl/div_issue_ctrl.sv
// Shared iterative divider sequencer for div.w/mod.w/div.wu/mod.wu in EX.
// Radix-2^ITER restoring shift-subtract loop; holds the result until MEM accepts it.
module div_issue_ctrl #(
  parameter int DATA_W = 32,
  parameter int ITER   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              div_valid,
  input  logic [1:0]        div_op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              flush,
  input  logic              out_ready,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic              busy,
  output logic              ex_stall
);

  localparam int STEPS = DATA_W / ITER;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvsr_q, dvsr_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              op_rem_q, op_rem_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;

  logic              fire;
  logic              is_signed, s1_neg, s2_neg, div_zero;
  logic [DATA_W-1:0] abs1, abs2;
  logic [DATA_W-1:0] step_rem, step_quo;
  logic [DATA_W-1:0] fix_quo, fix_rem;

  assign fire = div_valid & (state_q == IDLE) & ~flush;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (fire)          state_d = CALC;
        CALC:    if (cnt_q == LAST) state_d = DONE;
        DONE:    if (out_ready)     state_d = IDLE;
        default:                    state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    ex_stall  = div_valid & ~((state_q == DONE) & out_ready);
    result    = result_q;
  end

  // Divide-by-zero runs unsigned so the loop itself yields all-ones / raw src1.
  always_comb begin
    is_signed = ~div_op[1];
    s1_neg    = is_signed & src1[DATA_W-1];
    s2_neg    = is_signed & src2[DATA_W-1];
    div_zero  = (src2 == '0);
    abs1      = (s1_neg & ~div_zero) ? -src1 : src1;
    abs2      = s2_neg ? -src2 : src2;
  end

  always_comb begin
    logic [DATA_W:0] part;
    part     = '0;
    step_rem = rem_q;
    step_quo = quo_q;
    for (int i = 0; i < ITER; i++) begin
      part     = {step_rem, step_quo[DATA_W-1]};
      step_quo = {step_quo[DATA_W-2:0], 1'b0};
      if (part >= {1'b0, dvsr_q}) begin
        part        = part - {1'b0, dvsr_q};
        step_quo[0] = 1'b1;
      end
      step_rem = part[DATA_W-1:0];
    end
    fix_quo = q_neg_q ? -step_quo : step_quo;
    fix_rem = r_neg_q ? -step_rem : step_rem;
  end

  always_comb begin
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    result_d = result_q;
    op_rem_d = op_rem_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    if (flush) begin
      cnt_d = '0;
    end else if (fire) begin
      cnt_d    = '0;
      rem_d    = '0;
      quo_d    = abs1;
      dvsr_d   = abs2;
      op_rem_d = div_op[0];
      q_neg_d  = ~div_zero & (s1_neg ^ s2_neg);
      r_neg_d  = ~div_zero & s1_neg;
    end else if (state_q == CALC) begin
      rem_d = step_rem;
      quo_d = step_quo;
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == LAST) begin
        result_d = op_rem_q ? fix_rem : fix_quo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      result_q <= '0;
      op_rem_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      result_q <= result_d;
      op_rem_q <= op_rem_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl: one ITER=1 instance and one ITER=2 instance
// sharing operand/flush/reset inputs, each with its own div_valid.
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        v1, v2;
  logic [1:0]  div_op;
  logic [31:0] src1, src2;
  logic        flush;
  logic        out_ready;

  logic        ir1, ov1, busy1, st1;
  logic [31:0] res1;
  logic        ir2, ov2, busy2, st2;
  logic [31:0] res2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div_issue_ctrl #(.DATA_W(32), .ITER(1)) u_dut (
    .clk(clk), .reset(reset), .div_valid(v1), .div_op(div_op),
    .src1(src1), .src2(src2), .flush(flush), .out_ready(out_ready),
    .in_ready(ir1), .out_valid(ov1), .result(res1), .busy(busy1), .ex_stall(st1)
  );

  div_issue_ctrl #(.DATA_W(32), .ITER(2)) u_dut2 (
    .clk(clk), .reset(reset), .div_valid(v2), .div_op(div_op),
    .src1(src1), .src2(src2), .flush(flush), .out_ready(out_ready),
    .in_ready(ir2), .out_valid(ov2), .result(res2), .busy(busy2), .ex_stall(st2)
  );

  function automatic logic [31:0] f_res(input bit s);
    return s ? res2 : res1;
  endfunction
  function automatic logic f_ov(input bit s);
    return s ? ov2 : ov1;
  endfunction
  function automatic logic f_busy(input bit s);
    return s ? busy2 : busy1;
  endfunction
  function automatic logic f_ir(input bit s);
    return s ? ir2 : ir1;
  endfunction
  function automatic logic f_st(input bit s);
    return s ? st2 : st1;
  endfunction

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit s, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    div_op = op;
    src1   = a;
    src2   = b;
    if (s) v2 = 1'b1;
    else   v1 = 1'b1;
  endtask

  // Fire an op, then scramble the operands to show they are only sampled at fire.
  task automatic start_op(input bit s, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    applyStimulus(s, op, a, b);
    #1;
    checkOutput("in_ready_at_fire", 32'(f_ir(s)), 32'd1);
    checkOutput("stall_at_fire", 32'(f_st(s)), 32'd1);
    tick;
    checkOutput("stall_in_calc", 32'(f_st(s)), 32'd1);
    src1   = $urandom;
    src2   = $urandom;
    div_op = op ^ 2'b01;
  endtask

  task automatic wait_done(input bit s, input int lat);
    int n;
    n = 1;
    while (!f_ov(s) && n < 80) begin
      tick;
      n++;
    end
    checkOutput("latency", 32'(n), 32'(lat));
  endtask

  task automatic finish_op(input bit s, input string tag, input logic [31:0] exp);
    checkOutput(tag, f_res(s), exp);
    out_ready = 1'b1;
    #1;
    checkOutput("stall_release", 32'(f_st(s)), 32'd0);
    tick;
    if (s) v2 = 1'b0;
    else   v1 = 1'b0;
    #1;
    checkOutput("idle_after_accept", {30'd0, f_busy(s), f_ov(s)}, 32'd0);
  endtask

  task automatic run_op(input bit s, input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    start_op(s, op, a, b);
    wait_done(s, lat);
    finish_op(s, tag, exp);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; v1 = 1'b0; v2 = 1'b0; div_op = 2'd0;
    src1 = '0; src2 = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) tick;
    checkOutput("reset_result", res1, 32'h0);
    checkOutput("reset_flags", {28'd0, ir1, ov1, busy1, st1}, 32'b1000);
    checkOutput("reset_result_iter2", res2, 32'h0);
    reset = 1'b0;
    tick;

    run_op(0, "div.w -7/2",      2'd0, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33);
    run_op(0, "mod.w -7/2",      2'd1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33);
    run_op(0, "div.w 7/-2",      2'd0, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op(0, "mod.w 7/-2",      2'd1, 32'd7,         32'hFFFF_FFFE, 32'h1,         33);
    run_op(0, "div.wu ffff/10",  2'd2, 32'hFFFF_FFFF, 32'h10,       32'h0FFF_FFFF, 33);
    run_op(0, "mod.wu ffff/10",  2'd3, 32'hFFFF_FFFF, 32'h10,       32'hF,         33);
    run_op(0, "div.w 5/0",       2'd0, 32'd5,         32'd0,        32'hFFFF_FFFF, 33);
    run_op(0, "mod.w 5/0",       2'd1, 32'd5,         32'd0,        32'd5,         33);
    run_op(0, "mod.w -7/0",      2'd1, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 33);
    run_op(0, "div.w ovf",       2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
    run_op(0, "mod.w ovf",       2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         33);

    // Result held while MEM is not ready.
    out_ready = 1'b0;
    start_op(0, 2'd2, 32'd100, 32'd7);
    wait_done(0, 33);
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_valid", 32'(ov1), 32'd1);
      checkOutput("hold_result", res1, 32'hE);
      checkOutput("hold_stall", 32'(st1), 32'd1);
      tick;
    end
    finish_op(0, "div.wu 100/7 held", 32'hE);

    // Flush in the middle of CALC.
    start_op(0, 2'd0, 32'd100, 32'd7);
    repeat (10) tick;
    flush = 1'b1;
    v1 = 1'b0;
    tick;
    flush = 1'b0;
    #1;
    checkOutput("flush_calc", {30'd0, busy1, ov1}, 32'd0);
    tick;
    checkOutput("flush_stays_idle", 32'(busy1), 32'd0);
    run_op(0, "mod.wu 100/7 after flush", 2'd3, 32'd100, 32'd7, 32'd2, 33);

    // Flush together with div_valid in IDLE does not fire.
    applyStimulus(0, 2'd0, 32'd9, 32'd3);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    v1 = 1'b0;
    #1;
    checkOutput("flush_blocks_fire", 32'(busy1), 32'd0);

    // Flush beats out_ready in DONE.
    out_ready = 1'b0;
    start_op(0, 2'd0, 32'd9, 32'd3);
    wait_done(0, 33);
    checkOutput("done_before_flush", res1, 32'd3);
    out_ready = 1'b1;
    flush = 1'b1;
    v1 = 1'b0;
    tick;
    flush = 1'b0;
    #1;
    checkOutput("flush_done", {30'd0, busy1, ov1}, 32'd0);

    // Reset while in DONE.
    out_ready = 1'b0;
    start_op(0, 2'd1, 32'd9, 32'd4);
    wait_done(0, 33);
    checkOutput("mod.w 9/4", res1, 32'd1);
    reset = 1'b1;
    v1 = 1'b0;
    tick;
    checkOutput("reset_done_result", res1, 32'h0);
    checkOutput("reset_done_flags", {28'd0, ir1, ov1, busy1, st1}, 32'b1000);
    reset = 1'b0;
    out_ready = 1'b1;
    tick;

    run_op(1, "i2 div.w -7/2",     2'd0, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 17);
    run_op(1, "i2 mod.w -7/2",     2'd1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 17);
    run_op(1, "i2 div.wu ffff/10", 2'd2, 32'hFFFF_FFFF, 32'h10,       32'h0FFF_FFFF, 17);
    run_op(1, "i2 mod.wu ffff/10", 2'd3, 32'hFFFF_FFFF, 32'h10,       32'hF,         17);
    run_op(1, "i2 div.w 5/0",      2'd0, 32'd5,         32'd0,        32'hFFFF_FFFF, 17);
    run_op(1, "i2 mod.w 5/0",      2'd1, 32'd5,         32'd0,        32'd5,         17);
    run_op(1, "i2 div.w ovf",      2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 17);
    run_op(1, "i2 mod.w ovf",      2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
